// File: rtl/uart_pkg.sv
// uart_pkg: state encoding, default widths and ALU opcodes shared by the UART/ALU controller, the ALU and the bench.
package uart_pkg;
  localparam int NBIT_DATA_DEF = 8;
  localparam int NBIT_OP_DEF = 6;
  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    CALC    = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5
  } state_t;
  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;
endpackage

// File: rtl/uart_alu_ctrl_if.sv
// uart_alu_ctrl_if: UART receive/transmit handshake and ALU operand/result bundle around the controller.
interface uart_alu_ctrl_if
  import uart_pkg::*;
#(
  parameter int NBIT_DATA = NBIT_DATA_DEF,
  parameter int NBIT_OP = NBIT_OP_DEF
);
  logic rx_done_tick;
  logic [NBIT_DATA-1:0] rx_data;
  logic tx_done_tick;
  logic [NBIT_DATA-1:0] alu_result;
  logic [NBIT_DATA-1:0] alu_a;
  logic [NBIT_DATA-1:0] alu_b;
  logic [NBIT_OP-1:0] alu_op;
  logic tx_start;
  logic [NBIT_DATA-1:0] tx_data;
  logic busy;
  logic rx_overrun_tick;
  logic timeout_tick;
  modport master (
    input rx_done_tick, rx_data, tx_done_tick, alu_result,
    output alu_a, alu_b, alu_op, tx_start, tx_data, busy, rx_overrun_tick, timeout_tick
  );
  modport slave (
    output rx_done_tick, rx_data, tx_done_tick, alu_result,
    input alu_a, alu_b, alu_op, tx_start, tx_data, busy, rx_overrun_tick, timeout_tick
  );
endinterface

// File: rtl/uart_alu_ctrl_frame_timer.sv
// frame_timer: inter-byte timeout counter; tc marks the terminal count while enabled and not being cleared.
module frame_timer #(
  parameter int TIMEOUT_CYCLES = 40000000
) (
  input  logic CLK,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int W = $clog2(TIMEOUT_CYCLES);
  logic [W-1:0] cnt;
  assign tc = en && !clr && cnt == W'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge CLK)
    cnt <= (!reset || clr || !en || tc) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_alu_ctrl.sv
// uart_alu_ctrl: collects A, B, opcode bytes from the UART, feeds the ALU and transmits the result.
// Optional inter-byte timeout enabled by UART_ALU_CTRL_TIMEOUT_EN.
module uart_alu_ctrl
  import uart_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 40000000
) (
  input logic CLK,
  input logic reset,
  uart_alu_ctrl_if.master bus
);
  state_t state;
  logic tmo;
`ifdef UART_ALU_CTRL_TIMEOUT_EN
  frame_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .CLK(CLK),
    .reset(reset),
    .clr(bus.rx_done_tick),
    .en(state == WAIT_B || state == WAIT_OP),
    .tc(tmo)
  );
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state <= WAIT_A;
      bus.alu_a <= '0;
      bus.alu_b <= '0;
      bus.alu_op <= '0;
      bus.tx_data <= '0;
      bus.tx_start <= 1'b0;
      bus.busy <= 1'b0;
      bus.rx_overrun_tick <= 1'b0;
      bus.timeout_tick <= 1'b0;
    end else begin
      bus.tx_start <= 1'b0;
      bus.timeout_tick <= 1'b0;
      // bytes arriving while a result is in flight are dropped, not queued
      bus.rx_overrun_tick <= bus.rx_done_tick && (state == CALC || state == SEND || state == WAIT_TX);
      case (state)
        WAIT_A:
          if (bus.rx_done_tick) begin
            bus.alu_a <= bus.rx_data;
            state <= WAIT_B;
          end
        WAIT_B:
          if (bus.rx_done_tick) begin
            bus.alu_b <= bus.rx_data;
            state <= WAIT_OP;
          end else if (tmo) begin
            state <= WAIT_A;
            bus.timeout_tick <= 1'b1;
          end
        WAIT_OP:
          if (bus.rx_done_tick) begin
            bus.alu_op <= bus.rx_data[$bits(bus.alu_op)-1:0];
            bus.busy <= 1'b1;
            state <= CALC;
          end else if (tmo) begin
            state <= WAIT_A;
            bus.timeout_tick <= 1'b1;
          end
        CALC: begin
          bus.tx_data <= bus.alu_result;
          bus.tx_start <= 1'b1;
          state <= SEND;
        end
        SEND: state <= WAIT_TX;
        WAIT_TX:
          if (bus.tx_done_tick) begin
            bus.busy <= 1'b0;
            state <= WAIT_A;
          end
        default: state <= WAIT_A;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_alu_ctrl.sv
// tb_uart_alu_ctrl: directed-vector bench for uart_alu_ctrl with an ALU model on alu_result.
module tb_uart_alu_ctrl;
  import uart_pkg::*;
  logic CLK = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int bad = 0;
  uart_alu_ctrl_if bus ();
  uart_alu_ctrl #(.TIMEOUT_CYCLES(100)) dut (.CLK(CLK), .reset(reset), .bus(bus));
  always #5 CLK = ~CLK;
  function automatic logic [7:0] alu_f(logic [7:0] a, logic [7:0] b, logic [5:0] op);
    case (op)
      OP_ADD: return a + b;
      OP_SUB: return a - b;
      OP_AND: return a & b;
      OP_OR:  return a | b;
      OP_XOR: return a ^ b;
      OP_SRA: return 8'($signed(a) >>> b);
      OP_SRL: return a >> b;
      OP_NOR: return ~(a | b);
      default: return 8'h00;
    endcase
  endfunction
  always_comb bus.alu_result = alu_f(bus.alu_a, bus.alu_b, bus.alu_op);
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask
  task automatic send(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_done_tick = 1'b1;
    step();
    bus.rx_done_tick = 1'b0;
  endtask
  task automatic tx_done();
    bus.tx_done_tick = 1'b1;
    step();
    bus.tx_done_tick = 1'b0;
  endtask
  function automatic logic [31:0] st();
    return 32'(dut.state);
  endfunction
  initial begin
    bus.rx_done_tick = 1'b0;
    bus.rx_data = '0;
    bus.tx_done_tick = 1'b0;
    reset = 1'b0;
    step(3);
    reset = 1'b1;
    step();
    chk("rst_state", st(), 32'(WAIT_A));
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_outs", {bus.alu_a, bus.alu_b, 2'b00, bus.alu_op, bus.tx_data}, 0);
    chk("rst_ticks", {bus.tx_start, bus.rx_overrun_tick, bus.timeout_tick}, 0);
    // frame 1: ADD
    send(8'h05);
    chk("f1_a", 32'(bus.alu_a), 32'h05);
    chk("f1_stB", st(), 32'(WAIT_B));
    send(8'h03);
    send(8'h20);
    chk("f1_op", 32'(bus.alu_op), 32'h20);
    chk("f1_b", 32'(bus.alu_b), 32'h03);
    chk("f1_calc_busy", 32'(bus.busy), 1);
    chk("f1_k1_start", 32'(bus.tx_start), 0);
    step();
    chk("f1_k2_start", 32'(bus.tx_start), 1);
    chk("f1_txd", 32'(bus.tx_data), 32'h08);
    step();
    chk("f1_start_1cyc", 32'(bus.tx_start), 0);
    step(5);
    chk("f1_no_restart", 32'(bus.tx_start), 0);
    chk("f1_stTX", st(), 32'(WAIT_TX));
    tx_done();
    chk("f1_done_st", st(), 32'(WAIT_A));
    chk("f1_done_busy", 32'(bus.busy), 0);
    // frame 2: OR with overrun byte
    send(8'hF0);
    send(8'h0F);
    send(8'h25);
    step(2);
    chk("f2_txd", 32'(bus.tx_data), 32'hFF);
    send(8'hAA);
    chk("f2_ovr", 32'(bus.rx_overrun_tick), 1);
    chk("f2_ovr_st", st(), 32'(WAIT_TX));
    step();
    chk("f2_ovr_1cyc", 32'(bus.rx_overrun_tick), 0);
    tx_done();
    send(8'h07);
    chk("f3_clean_a", 32'(bus.alu_a), 32'h07);
    send(8'h02);
    send(8'hE2);
    chk("f3_op_trunc", 32'(bus.alu_op), 32'h22);
    // reset in CALC must suppress tx_start on the same edge
    reset = 1'b0;
    step();
    chk("rcalc_start", 32'(bus.tx_start), 0);
    chk("rcalc_st", st(), 32'(WAIT_A));
    reset = 1'b1;
    // frame 4: SUB, reset in WAIT_TX
    send(8'h07);
    send(8'h02);
    send(8'h22);
    step();
    chk("f4_txd", 32'(bus.tx_data), 32'h05);
    step(2);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("rtx_st", st(), 32'(WAIT_A));
    chk("rtx_clr", {bus.alu_a, bus.tx_data, 7'd0, bus.busy, bus.tx_start}, 0);
    tx_done();
    chk("rtx_ignore_done", st(), 32'(WAIT_A));
    // frame 5: AND, then simultaneous rx/tx done
    send(8'h0C);
    send(8'h0A);
    send(8'h24);
    step(2);
    chk("f5_txd", 32'(bus.tx_data), 32'h08);
    bus.rx_data = 8'h55;
    bus.rx_done_tick = 1'b1;
    bus.tx_done_tick = 1'b1;
    step();
    bus.rx_done_tick = 1'b0;
    bus.tx_done_tick = 1'b0;
    chk("sim_st", st(), 32'(WAIT_A));
    chk("sim_ovr", 32'(bus.rx_overrun_tick), 1);
    chk("sim_a", 32'(bus.alu_a), 32'h0C);
    // frame 6: SRA, tx_done outside WAIT_TX ignored
    send(8'h80);
    tx_done();
    chk("ign_done_st", st(), 32'(WAIT_B));
    send(8'h02);
    send(8'h03);
    step();
    chk("f6_sra", 32'(bus.tx_data), 32'hE0);
    step();
    tx_done();
    // inter-byte idle behaviour
    send(8'h11);
`ifdef UART_ALU_CTRL_TIMEOUT_EN
    step(99);
    chk("to_pre_st", st(), 32'(WAIT_B));
    chk("to_pre_tick", 32'(bus.timeout_tick), 0);
    step();
    chk("to_tick", 32'(bus.timeout_tick), 1);
    chk("to_st", st(), 32'(WAIT_A));
    chk("to_keep_a", 32'(bus.alu_a), 32'h11);
    step();
    chk("to_tick_1cyc", 32'(bus.timeout_tick), 0);
    send(8'h11);
    step(99);
    send(8'h22);
    chk("to_tc_accept_st", st(), 32'(WAIT_OP));
    chk("to_tc_accept_b", 32'(bus.alu_b), 32'h22);
    chk("to_tc_no_tick", 32'(bus.timeout_tick), 0);
`else
    step(200);
    chk("idle_st", st(), 32'(WAIT_B));
    chk("idle_no_tick", 32'(bus.timeout_tick), 0);
    send(8'h22);
    send(8'h26);
    step();
    chk("idle_xor", 32'(bus.tx_data), 32'h33);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
